// File: rtl/key_voice_allocator_if.sv
// Keycode-in / highlight-and-voice-out bundle between the USB path, the allocator and the renderer.
interface key_voice_allocator_if;
  logic [31:0] keycode;
  logic [3:0]  highlighter_0;
  logic [3:0]  highlighter_1;
  logic [3:0]  highlighter_2;
  logic [3:0]  highlighter_3;
  logic [3:0]  slot_active;
  logic [3:0]  slot_held;
  logic [3:0]  note_on_pulse;
  logic [3:0]  note_off_pulse;
  logic        busy;

  modport master (
    output keycode,
    input  highlighter_0, highlighter_1, highlighter_2, highlighter_3,
    input  slot_active, slot_held, note_on_pulse, note_off_pulse, busy
  );

  modport slave (
    input  keycode,
    output highlighter_0, highlighter_1, highlighter_2, highlighter_3,
    output slot_active, slot_held, note_on_pulse, note_off_pulse, busy
  );
endinterface

// File: rtl/key_voice_allocator.sv
// Maps HID keycodes to notes 1..12 and assigns them to 4 stable voice slots with a release linger.
// Optional macro KEY_ALLOC_STEAL_EN: when no slot is free, steal the releasing slot closest to expiry.
module key_voice_slot #(
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             tick,
  input  logic             wr,
  input  logic [3:0]       wr_note,
  input  logic             wr_active,
  input  logic             wr_held,
  input  logic [CNT_W-1:0] wr_cnt,
  output logic [3:0]       note,
  output logic             active,
  output logic             held,
  output logic [CNT_W-1:0] cnt
);
  // note is cleared whenever the slot frees, so it doubles as the highlighter register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      note   <= '0;
      active <= 1'b0;
      held   <= 1'b0;
      cnt    <= '0;
    end else if (wr) begin
      note   <= wr_note;
      active <= wr_active;
      held   <= wr_held;
      cnt    <= wr_cnt;
    end else if (tick && active && !held) begin
      if (cnt <= CNT_W'(1)) begin
        note   <= '0;
        active <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end
endmodule

module key_voice_allocator #(
  parameter int RELEASE_FRAMES = 15,
  parameter int CNT_W          = 6
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  key_voice_allocator_if.slave bus
);
  localparam int NUM_SLOTS = 4;

  typedef enum logic [2:0] {
    IDLE, DECODE, RELEASE, ALLOC0, ALLOC1, ALLOC2, ALLOC3
  } state_t;

  state_t state, state_nxt;

  logic [2:0]                            fsync;
  logic                                  tick;
  logic [31:0]                           last_kc;
  logic [NUM_SLOTS-1:0][3:0]             n_reg, dec_n;
  logic [12:0]                           mask_reg, dec_mask;
  logic                                  is_alloc;
  logic [1:0]                            alloc_idx;
  logic [3:0]                            cur_n;

  logic [NUM_SLOTS-1:0][3:0]             note, w_note;
  logic [NUM_SLOTS-1:0]                  active, held, w_active, w_held, wr;
  logic [NUM_SLOTS-1:0][CNT_W-1:0]       cnt, w_cnt;
  logic [NUM_SLOTS-1:0]                  on_nxt, off_nxt, on_pulse, off_pulse;

  logic       hit_any, free_any, steal_any;
  logic [1:0] hit_s, free_s, steal_s;

  function automatic logic [3:0] key_to_note(input logic [7:0] code);
    case (code)
      8'h04: key_to_note = 4'd1;
      8'h1A: key_to_note = 4'd2;
      8'h16: key_to_note = 4'd3;
      8'h08: key_to_note = 4'd4;
      8'h07: key_to_note = 4'd5;
      8'h09: key_to_note = 4'd6;
      8'h17: key_to_note = 4'd7;
      8'h0A: key_to_note = 4'd8;
      8'h1C: key_to_note = 4'd9;
      8'h0B: key_to_note = 4'd10;
      8'h18: key_to_note = 4'd11;
      8'h0D: key_to_note = 4'd12;
      default: key_to_note = 4'd0;
    endcase
  endfunction

  // frame_clk crosses in through two flops; the third flop feeds the rising-edge detect
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) fsync <= '0;
    else          fsync <= {fsync[1:0], frame_clk};
  end
  assign tick = fsync[1] & ~fsync[2];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.keycode != last_kc) state_nxt = DECODE;
      DECODE:  state_nxt = RELEASE;
      RELEASE: state_nxt = ALLOC0;
      ALLOC0:  state_nxt = ALLOC1;
      ALLOC1:  state_nxt = ALLOC2;
      ALLOC2:  state_nxt = ALLOC3;
      ALLOC3:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    is_alloc  = 1'b0;
    alloc_idx = 2'd0;
    case (state)
      ALLOC0: begin is_alloc = 1'b1; alloc_idx = 2'd0; end
      ALLOC1: begin is_alloc = 1'b1; alloc_idx = 2'd1; end
      ALLOC2: begin is_alloc = 1'b1; alloc_idx = 2'd2; end
      ALLOC3: begin is_alloc = 1'b1; alloc_idx = 2'd3; end
      default: ;
    endcase
  end
  assign bus.busy = (state != IDLE);

  // later duplicates of an already-seen note are dropped so each note claims one slot
  always_comb begin
    dec_n    = '0;
    dec_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      dec_n[i] = key_to_note(last_kc[8*i +: 8]);
      for (int j = 0; j < i; j++)
        if (dec_n[i] == dec_n[j]) dec_n[i] = 4'd0;
      if (dec_n[i] != 4'd0) dec_mask[dec_n[i]] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_kc  <= '0;
      n_reg    <= '0;
      mask_reg <= '0;
    end else begin
      if (state == IDLE && bus.keycode != last_kc) last_kc <= bus.keycode;
      if (state == DECODE) begin
        n_reg    <= dec_n;
        mask_reg <= dec_mask;
      end
    end
  end

  assign cur_n = n_reg[alloc_idx];

  // slot lookups for the current ALLOC note: existing owner, lowest free, steal victim
  always_comb begin
    hit_any   = 1'b0;
    hit_s     = 2'd0;
    free_any  = 1'b0;
    free_s    = 2'd0;
    steal_any = 1'b0;
    steal_s   = 2'd0;
    for (int s = 0; s < NUM_SLOTS; s++)
      if (active[s] && note[s] == cur_n) begin
        hit_any = 1'b1;
        hit_s   = 2'(s);
      end
    for (int s = NUM_SLOTS-1; s >= 0; s--)
      if (!active[s]) begin
        free_any = 1'b1;
        free_s   = 2'(s);
      end
    for (int s = 0; s < NUM_SLOTS; s++)
      if (active[s] && !held[s] && (!steal_any || cnt[s] < cnt[steal_s])) begin
        steal_any = 1'b1;
        steal_s   = 2'(s);
      end
  end

  always_comb begin
    wr       = '0;
    w_note   = note;
    w_active = active;
    w_held   = held;
    w_cnt    = cnt;
    on_nxt   = '0;
    off_nxt  = '0;
    if (state == RELEASE) begin
      for (int s = 0; s < NUM_SLOTS; s++)
        if (held[s] && !mask_reg[note[s]]) begin
          wr[s]      = 1'b1;
          w_held[s]  = 1'b0;
          w_cnt[s]   = CNT_W'(RELEASE_FRAMES);
          off_nxt[s] = 1'b1;
          if (RELEASE_FRAMES == 0) begin
            w_active[s] = 1'b0;
            w_note[s]   = 4'd0;
          end
        end
    end else if (is_alloc && cur_n != 4'd0) begin
      if (hit_any) begin
        if (!held[hit_s]) begin
          wr[hit_s]     = 1'b1;
          w_held[hit_s] = 1'b1;
          w_cnt[hit_s]  = '0;
          on_nxt[hit_s] = 1'b1;
        end
      end else if (free_any) begin
        wr[free_s]       = 1'b1;
        w_note[free_s]   = cur_n;
        w_active[free_s] = 1'b1;
        w_held[free_s]   = 1'b1;
        w_cnt[free_s]    = '0;
        on_nxt[free_s]   = 1'b1;
      end
`ifdef KEY_ALLOC_STEAL_EN
      else if (steal_any) begin
        // victim already sent its note-off when it was released
        wr[steal_s]       = 1'b1;
        w_note[steal_s]   = cur_n;
        w_active[steal_s] = 1'b1;
        w_held[steal_s]   = 1'b1;
        w_cnt[steal_s]    = '0;
        on_nxt[steal_s]   = 1'b1;
      end
`else
      else if (steal_any && 1'b0) begin
        wr[steal_s] = 1'b0;
      end
`endif
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    key_voice_slot #(.CNT_W(CNT_W)) u_slot (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .tick      (tick),
      .wr        (wr[g]),
      .wr_note   (w_note[g]),
      .wr_active (w_active[g]),
      .wr_held   (w_held[g]),
      .wr_cnt    (w_cnt[g]),
      .note      (note[g]),
      .active    (active[g]),
      .held      (held[g]),
      .cnt       (cnt[g])
    );
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      on_pulse  <= '0;
      off_pulse <= '0;
    end else begin
      on_pulse  <= on_nxt;
      off_pulse <= off_nxt;
    end
  end

  assign bus.highlighter_0  = note[0];
  assign bus.highlighter_1  = note[1];
  assign bus.highlighter_2  = note[2];
  assign bus.highlighter_3  = note[3];
  assign bus.slot_active    = active;
  assign bus.slot_held      = held;
  assign bus.note_on_pulse  = on_pulse;
  assign bus.note_off_pulse = off_pulse;
endmodule

// File: doc/key_voice_allocator.md
Name: key_voice_allocator

Overview:
- Sits directly upstream of the keyboard renderer and drives its four highlighter inputs.
- Takes the 32-bit USB keycode word (four 8-bit HID usage codes) from the NIOS/USB path and maps letter keys to note indices 1..12.
- Assigns up to 4 simultaneous notes to stable slots. A released note keeps its slot for a programmable number of frames so the highlight lingers.
- Also emits per-slot note-on/off pulses for the synth voices.

Parameters:
- RELEASE_FRAMES, 15: frame ticks a released note stays in its slot; 0 means free immediately.
- CNT_W, 6: width of the per-slot hold counter; must satisfy RELEASE_FRAMES < 2^CNT_W.

Ports:
- Clk  in  1  50 MHz system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_clk  in  1  display frame clock; asynchronous to Clk and synchronized internally
- keycode  in  32  four HID codes; byte i = keycode[8i+7:8i]; 0x00 = none
- highlighter_0..highlighter_3  out  4 each  note in slot i (1..12), 0 if slot inactive
- slot_active  out  4  slot i holds a note, held or releasing
- slot_held  out  4  slot i key physically down
- note_on_pulse  out  4  one-Clk pulse when slot i starts or re-holds a note
- note_off_pulse  out  4  one-Clk pulse when slot i key is released
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: the whole design uses one clock (Clk) and an asynchronous, active-low reset (Reset_n). While Reset_n is low:
  - all outputs are 0;
  - last_kc and all slot state are 0;
  - the FSM is in IDLE;
  - the frame synchronizer is cleared.
  - Reset asserted mid-update aborts the update with no partial commit visible after release.
- Key map (HID -> note):
  - 04->1, 1A->2, 16->3, 08->4, 07->5, 09->6
  - 17->7, 0A->8, 1C->9, 0B->10, 18->11, 0D->12
  - Any other code maps to 0 (ignored).
- Frame tick: frame_clk goes through a 2-flop synchronizer plus rising-edge detect, giving a one-Clk tick.
  - On a tick, each slot that is active and not held decrements its counter.
  - A decrement from 1 to 0 frees the slot: active=0, highlighter=0.
  - Ticks are processed independently of the FSM.
- FSM: IDLE -> DECODE -> RELEASE -> ALLOC0 -> ALLOC1 -> ALLOC2 -> ALLOC3 -> IDLE. Each state is one cycle.
  - IDLE: if keycode != last_kc, latch keycode into kc_reg and last_kc, then go to DECODE. Otherwise stay.
  - DECODE: map bytes to n0..n3. If n_i equals an earlier n_j, set n_i=0. Build present mask[12:1].
  - RELEASE: for each held slot whose note is not in the mask:
    - held=0, counter=RELEASE_FRAMES, note_off_pulse.
    - If RELEASE_FRAMES==0, also active=0 and highlighter=0 in the same cycle.
  - ALLOCi (n_i != 0), resolved in this priority order:
    - a) slot already has n_i and is held: no action.
    - b) slot already has n_i and is releasing: held=1, counter=0, note_on_pulse.
    - c) otherwise take the lowest-index inactive slot: note=n_i, active=1, held=1, note_on_pulse.
    - d) otherwise handle per the optional feature below.
  - Keycode changes while busy are not lost: on return to IDLE, keycode is compared against last_kc again.
- Latency: keycode change to highlighter update is 4 to 7 Clk cycles (the new note appears after its ALLOCi state). Pulses are registered.
- Simultaneous events: if a tick and a RELEASE/ALLOC write hit the same slot in the same cycle, the FSM write wins and that tick is not applied to that slot. Other slots still decrement.
- highlighter_i is registered and equals the slot note when active, else 0.

Optional Feature:
- Macro: KEY_ALLOC_STEAL_EN.
- Defined: in case d), steal the releasing slot with the smallest counter, lowest index on ties, and assign n_i with note_on_pulse. No note_off_pulse is issued, since that slot was already released. If all 4 slots are held, n_i is dropped.
- Undefined: in case d), n_i is always dropped and slot state is unchanged.

Test Plan:
- Reset, then keycode=0x00000004 -> within 7 Clk: highlighter_0=1, slot_active=0001, slot_held=0001, note_on_pulse=0001 for exactly 1 cycle.
- keycode=0x0D160704 -> highlighter_0..3 = 1, 5, 3, 12; slot_active=1111.
- From that state, keycode=0x0D160700 with RELEASE_FRAMES=15 -> note_off_pulse=0001 and slot_held=1110. highlighter_0 stays 1 through 14 frame ticks and becomes 0 on the 15th tick.
- Re-press 0x04 after 5 ticks of release -> slot0 re-held, note_on_pulse=0001, highlighter_0=1, no slot move. Also keycode=0x04040029 -> one slot with note 1; 0x29 ignored.
- Hold A,W,S,E; release A; wait 5 ticks; release W,S,E; press 0x0A.
  - With KEY_ALLOC_STEAL_EN: highlighter_0=8, slot0 held.
  - Without the macro: all highlighters unchanged and no note_on_pulse.
- Reset_n low during ALLOC2 of a 4-key update -> all outputs 0 asynchronously. After release with keycode unchanged, a full update recomputes from empty slots.
